// File: rtl/display_dp_sequencer.sv
// Display mode register for the seven-segment path: holds the current mode, drives the
// per-digit decimal points from a table, blanks briefly on every mode change and can blink the DP.
module display_dp_sequencer #(
    parameter int NUM_MODES    = 4,
    parameter int DIGITS       = 4,
    localparam int SEL_W       = $clog2(NUM_MODES),
    parameter logic [NUM_MODES*DIGITS-1:0] DP_TABLE = (NUM_MODES*DIGITS)'(16'h0020),
    parameter int DWELL_CYCLES = 100000000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_HALF   = 25000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [SEL_W-1:0]  mode_in,
    input  logic              mode_load,
    input  logic              next_pulse,
    input  logic              auto_en,
    input  logic              blink_en,
    output logic [SEL_W-1:0]  mode,
    output logic [DIGITS-1:0] dp,
    output logic              blank,
    output logic              mode_changed
);

    localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int BC_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int BK_W = (BLINK_HALF   > 1) ? $clog2(BLINK_HALF)   : 1;

    localparam logic [SEL_W-1:0] LAST_MODE  = SEL_W'(NUM_MODES - 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
    localparam logic [BC_W-1:0]  BLANK_LAST = BC_W'(BLANK_CYCLES - 1);
    localparam logic [BK_W-1:0]  BLINK_LAST = BK_W'(BLINK_HALF - 1);

    logic [1:0]        rst_sync;
    logic              rst_n;
    logic [DW_W-1:0]   dwell_cnt;
    logic [BC_W-1:0]   blank_cnt;
    logic [BK_W-1:0]   blink_cnt;
    logic              phase;
    logic              in_range;
    logic              load_ok;
    logic              auto_tick;
    logic [SEL_W-1:0]  mode_succ;
    logic [SEL_W-1:0]  target;
    logic              change;
    logic              blank_next;
    logic              phase_next;
    logic [DIGITS-1:0] pattern;

    // Reset asserts immediately but releases in step with the clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // A power-of-two mode count makes every mode_in value legal.
    generate
        if (NUM_MODES == (1 << SEL_W)) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_partial_range
            assign in_range = (mode_in < SEL_W'(NUM_MODES));
        end
    endgenerate

    assign load_ok   = mode_load && in_range;
    assign auto_tick = auto_en && (dwell_cnt == DWELL_LAST);
    assign mode_succ = (mode == LAST_MODE) ? '0 : mode + 1'b1;
    assign pattern   = DP_TABLE[mode*DIGITS +: DIGITS];

    always_comb begin
        target = mode;
        if (load_ok)                       target = mode_in;
        else if (next_pulse || auto_tick)  target = mode_succ;
    end

    assign change     = (target != mode);
    assign blank_next = change || (blank && (blank_cnt != BLANK_LAST));
    assign phase_next = !blink_en ? 1'b1 : ((blink_cnt == BLINK_LAST) ? ~phase : phase);

    // dp looks ahead at blank and phase so it goes dark on the change edge itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode         <= '0;
            dp           <= DP_TABLE[DIGITS-1:0];
            blank        <= 1'b0;
            mode_changed <= 1'b0;
            dwell_cnt    <= '0;
            blank_cnt    <= '0;
            blink_cnt    <= '0;
            phase        <= 1'b1;
        end else begin
            mode_changed <= change;
            if (change) mode <= target;
            blank <= blank_next;

            if (change)                                 blank_cnt <= '0;
            else if (blank && (blank_cnt != BLANK_LAST)) blank_cnt <= blank_cnt + 1'b1;
            else                                        blank_cnt <= '0;

            if (!auto_en || change || auto_tick) dwell_cnt <= '0;
            else                                 dwell_cnt <= dwell_cnt + 1'b1;

            if (!blink_en || (blink_cnt == BLINK_LAST)) blink_cnt <= '0;
            else                                        blink_cnt <= blink_cnt + 1'b1;
            phase <= phase_next;

            dp <= blank_next ? '0 : (pattern & {DIGITS{phase_next}});
        end
    end

endmodule
